keypad_entry_ctrl: RTL and testbench

//  Sequences the scanned-keypad front end into complete operator entries. Consumes one-cycle key

---
 rtl/keypad_pkg.sv | 40 ++++
 rtl/keypad_idle_timer.sv | 42 ++++
 rtl/keypad_entry_ctrl.sv | 154 +++++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, terminator codes and the entry FSM state type.
// Used by the keypad scanner, keypad_entry_ctrl and the application FSM.
package keypad_pkg;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;

    localparam logic [2:0] TERM_HASH = 3'd0;
    localparam logic [2:0] TERM_A    = 3'd1;
    localparam logic [2:0] TERM_B    = 3'd2;
    localparam logic [2:0] TERM_C    = 3'd3;
    localparam logic [2:0] TERM_D    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_DONE
    } state_e;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

    function automatic logic is_letter(input logic [3:0] code);
        return (code >= KEY_A) && (code <= KEY_D);
    endfunction

    // '#' -> 0, A..D -> 1..4
    function automatic logic [2:0] term_of(input logic [3:0] code);
        if (code == KEY_HASH) begin
            return TERM_HASH;
        end
        return 3'(code - KEY_A + 4'd1);
    endfunction

endpackage

// File: rtl/keypad_idle_timer.sv
// Idle counter for the entry FSM.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   clr        synchronous clear (wins over en)
//   en         count one cycle; holds at TIMEOUT_CYCLES-1
//   expire     registered: counter currently holds TIMEOUT_CYCLES-1
module keypad_idle_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned WIDTH = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [WIDTH-1:0] LAST = WIDTH'(TIMEOUT_CYCLES - 1);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LAST)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            expire  <= 1'b0;
        end else begin
            count_q <= count_d;
            expire  <= (count_d == LAST);
        end
    end

endmodule

// File: rtl/keypad_entry_ctrl.sv
// Assembles scanned key strobes into operator entries (digits + terminator) and hands each
// finished entry downstream over a valid/ready handshake.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   key_valid, key_code           one-cycle key strobe and 4-bit code from the scanner
//   entry_valid, entry_ready      finished-entry handshake
//   entry_bcd/len/term            finished entry (newest digit in [3:0])
//   live_bcd/len                  digits currently being typed, 0 in IDLE
//   busy                          not in IDLE
//   err                           one-cycle pulse: key rejected
//   timeout                       one-cycle pulse: entry abandoned after idle timeout
module keypad_entry_ctrl
    import keypad_pkg::*;
#(
    parameter int unsigned MAX_DIGITS     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50_000_000,
    localparam int unsigned BUF_W = 4 * MAX_DIGITS,
    localparam int unsigned LEN_W = $clog2(MAX_DIGITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic             entry_valid,
    input  logic             entry_ready,
    output logic [BUF_W-1:0] entry_bcd,
    output logic [LEN_W-1:0] entry_len,
    output logic [2:0]       entry_term,
    output logic [BUF_W-1:0] live_bcd,
    output logic [LEN_W-1:0] live_len,
    output logic             busy,
    output logic             err,
    output logic             timeout
);

    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_DIGITS);
    localparam logic [LEN_W-1:0] ONE_LEN = LEN_W'(1);

    state_e           state_q;
    logic [BUF_W-1:0] digits_q;
    logic [LEN_W-1:0] len_q;
    logic             expire;

    assign live_bcd = digits_q;
    assign live_len = len_q;

    // Any key (accepted or rejected) and any state other than COLLECT restarts the idle count.
    keypad_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_idle_timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (key_valid || (state_q != ST_COLLECT)),
        .en    (state_q == ST_COLLECT),
        .expire(expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            digits_q    <= '0;
            len_q       <= '0;
            entry_valid <= 1'b0;
            entry_bcd   <= '0;
            entry_len   <= '0;
            entry_term  <= '0;
            busy        <= 1'b0;
            err         <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            err     <= 1'b0;
            timeout <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            digits_q <= BUF_W'(key_code);
                            len_q    <= ONE_LEN;
                            busy     <= 1'b1;
                            state_q  <= ST_COLLECT;
                        end else if (is_letter(key_code)) begin
                            // Bare command key: empty entry carrying only the terminator.
                            entry_valid <= 1'b1;
                            entry_bcd   <= '0;
                            entry_len   <= '0;
                            entry_term  <= term_of(key_code);
                            busy        <= 1'b1;
                            state_q     <= ST_DONE;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                ST_COLLECT: begin
                    if (key_valid) begin
                        if (is_digit(key_code)) begin
                            if (len_q == MAX_LEN) begin
                                err <= 1'b1;
                            end else begin
                                digits_q <= (digits_q << 4) | BUF_W'(key_code);
                                len_q    <= len_q + ONE_LEN;
                            end
                        end else if (key_code == KEY_STAR) begin
                            // Backspace; zero fills the top nibble.
                            digits_q <= digits_q >> 4;
                            len_q    <= len_q - ONE_LEN;
                            if (len_q == ONE_LEN) begin
                                busy    <= 1'b0;
                                state_q <= ST_IDLE;
                            end
                        end else begin
                            // '#' or A-D; len is never 0 in COLLECT.
                            entry_valid <= 1'b1;
                            entry_bcd   <= digits_q;
                            entry_len   <= len_q;
                            entry_term  <= term_of(key_code);
                            state_q     <= ST_DONE;
                        end
                    end else if (expire) begin
                        digits_q <= '0;
                        len_q    <= '0;
                        busy     <= 1'b0;
                        timeout  <= 1'b1;
                        state_q  <= ST_IDLE;
                    end
                end
                ST_DONE: begin
                    // Keys are dropped here, even on the accepting edge.
                    if (key_valid) begin
                        err <= 1'b1;
                    end
                    if (entry_ready) begin
                        entry_valid <= 1'b0;
                        entry_bcd   <= '0;
                        entry_len   <= '0;
                        entry_term  <= '0;
                        digits_q    <= '0;
                        len_q       <= '0;
                        busy        <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: begin
                    entry_valid <= 1'b0;
                    digits_q    <= '0;
                    len_q       <= '0;
                    busy        <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl with MAX_DIGITS=4, TIMEOUT_CYCLES=16.
module tb_keypad_entry_ctrl;
    import keypad_pkg::*;

    logic        clk;
    logic        rst;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        entry_valid;
    logic        entry_ready;
    logic [15:0] entry_bcd;
    logic [2:0]  entry_len;
    logic [2:0]  entry_term;
    logic [15:0] live_bcd;
    logic [2:0]  live_len;
    logic        busy;
    logic        err;
    logic        timeout;

    typedef struct packed {
        logic [15:0] bcd;
        logic [2:0]  len;
        logic [2:0]  term;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_pass = 0;

    keypad_entry_ctrl #(
        .MAX_DIGITS    (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .entry_valid(entry_valid),
        .entry_ready(entry_ready),
        .entry_bcd  (entry_bcd),
        .entry_len  (entry_len),
        .entry_term (entry_term),
        .live_bcd   (live_bcd),
        .live_len   (live_len),
        .busy       (busy),
        .err        (err),
        .timeout    (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Scoreboard: every handshake that will complete on the next edge is compared to the queue.
    always @(negedge clk) begin
        #1;
        if (!rst && entry_valid && entry_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL accept_unexpected: got bcd=%h len=%0d term=%0d, want no entry",
                         entry_bcd, entry_len, entry_term);
            end else begin
                mon_e = sb.pop_front();
                if ({entry_bcd, entry_len, entry_term} !== mon_e) begin
                    $display("FAIL accept_entry: got bcd=%h len=%0d term=%0d, want bcd=%h len=%0d term=%0d",
                             entry_bcd, entry_len, entry_term, mon_e.bcd, mon_e.len, mon_e.term);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    task automatic press(input logic [3:0] c);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic drain(input string name);
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (sb.size() != 0) $display("FAIL %s_drain: got %0d pending entries, want 0", name, sb.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        key_code = 4'd0;
        entry_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({entry_valid, entry_bcd, entry_len, entry_term, live_bcd, live_len, busy, err, timeout} !== '0)
            $display("FAIL reset_outputs: got valid=%b bcd=%h live=%h busy=%b, want all 0",
                     entry_valid, entry_bcd, live_bcd, busy);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_basic();
        entry_ready = 1'b1;
        press(4'd1);
        n_checks++;
        if ({busy, err, live_len} !== {1'b1, 1'b0, 3'd1})
            $display("FAIL basic_first: got busy=%b err=%b len=%0d, want 1 0 1", busy, err, live_len);
        else n_pass++;
        press(4'd2);
        press(4'd3);
        n_checks++;
        if ({live_bcd, live_len} !== {16'h0123, 3'd3})
            $display("FAIL basic_live: got %h/%0d, want 0123/3", live_bcd, live_len);
        else n_pass++;
        sb.push_back('{bcd: 16'h0123, len: 3'd3, term: TERM_HASH});
        press(KEY_HASH);
        n_checks++;
        if (entry_valid !== 1'b1) $display("FAIL basic_valid: got %b, want 1", entry_valid);
        else n_pass++;
        drain("basic");
        n_checks++;
        if ({entry_valid, busy, live_len} !== 5'b0)
            $display("FAIL basic_idle: got valid=%b busy=%b len=%0d, want 0 0 0", entry_valid, busy, live_len);
        else n_pass++;
    endtask

    task automatic test_hold();
        entry_ready = 1'b0;
        press(4'd4);
        press(4'd5);
        press(KEY_STAR);
        press(4'd6);
        sb.push_back('{bcd: 16'h0046, len: 3'd2, term: TERM_B});
        press(KEY_B);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({entry_valid, entry_bcd, entry_len, entry_term} !== {1'b1, 16'h0046, 3'd2, TERM_B})
                $display("FAIL hold_stable[%0d]: got v=%b %h/%0d/%0d, want 1 0046/2/2",
                         i, entry_valid, entry_bcd, entry_len, entry_term);
            else n_pass++;
            @(negedge clk);
        end
        entry_ready = 1'b1;
        drain("hold");
        n_checks++;
        if (busy !== 1'b0) $display("FAIL hold_idle: got busy=%b, want 0", busy);
        else n_pass++;
    endtask

    task automatic test_overflow();
        logic [3:0] seq[4];
        seq = '{4'd9, 4'd8, 4'd7, 4'd6};
        foreach (seq[i]) begin
            press(seq[i]);
            n_checks++;
            if (err !== 1'b0) $display("FAIL overflow_ok_err[%0d]: got %b, want 0", i, err);
            else n_pass++;
        end
        press(4'd5);
        n_checks++;
        if ({err, live_bcd, live_len} !== {1'b1, 16'h9876, 3'd4})
            $display("FAIL overflow_err: got err=%b %h/%0d, want 1 9876/4", err, live_bcd, live_len);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            press(KEY_STAR);
            n_checks++;
            if (err !== 1'b0) $display("FAIL backspace_err[%0d]: got %b, want 0", i, err);
            else n_pass++;
            if (i == 1) begin
                n_checks++;
                if ({live_bcd, live_len} !== {16'h0098, 3'd2})
                    $display("FAIL backspace_mid: got %h/%0d, want 0098/2", live_bcd, live_len);
                else n_pass++;
            end
        end
        n_checks++;
        if ({busy, live_len} !== 4'b0)
            $display("FAIL backspace_idle: got busy=%b len=%0d, want 0 0", busy, live_len);
        else n_pass++;
    endtask

    task automatic test_timeout();
        press(4'd7);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            n_checks++;
            if ({timeout, busy} !== 2'b01)
                $display("FAIL timeout_early[%0d]: got to=%b busy=%b, want 0 1", i, timeout, busy);
            else n_pass++;
        end
        @(negedge clk);
        n_checks++;
        if ({timeout, busy, live_len} !== {1'b1, 1'b0, 3'd0})
            $display("FAIL timeout_fire: got to=%b busy=%b len=%0d, want 1 0 0", timeout, busy, live_len);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (timeout !== 1'b0) $display("FAIL timeout_pulse: got %b, want 0", timeout);
        else n_pass++;
        // Second pass: a key lands exactly on the expiry edge.
        press(4'd7);
        repeat (14) @(negedge clk);
        press(4'd8);
        n_checks++;
        if ({timeout, busy, live_bcd, live_len} !== {1'b0, 1'b1, 16'h0078, 3'd2})
            $display("FAIL timeout_keywins: got to=%b busy=%b %h/%0d, want 0 1 0078/2",
                     timeout, busy, live_bcd, live_len);
        else n_pass++;
        entry_ready = 1'b1;
        sb.push_back('{bcd: 16'h0078, len: 3'd2, term: TERM_HASH});
        press(KEY_HASH);
        drain("timeout");
    endtask

    task automatic test_idle_keys();
        entry_ready = 1'b0;
        press(KEY_HASH);
        n_checks++;
        if ({err, busy} !== 2'b10) $display("FAIL idle_hash: got err=%b busy=%b, want 1 0", err, busy);
        else n_pass++;
        sb.push_back('{bcd: 16'h0000, len: 3'd0, term: TERM_D});
        press(KEY_D);
        n_checks++;
        if ({entry_valid, entry_len, entry_term, err} !== {1'b1, 3'd0, TERM_D, 1'b0})
            $display("FAIL idle_letter: got v=%b len=%0d term=%0d err=%b, want 1 0 4 0",
                     entry_valid, entry_len, entry_term, err);
        else n_pass++;
        press(4'd3);
        n_checks++;
        if ({err, entry_valid, entry_bcd, entry_len, entry_term} !== {1'b1, 1'b1, 16'h0, 3'd0, TERM_D})
            $display("FAIL done_key: got err=%b v=%b %h/%0d/%0d, want 1 1 0000/0/4",
                     err, entry_valid, entry_bcd, entry_len, entry_term);
        else n_pass++;
        entry_ready = 1'b1;
        drain("idle_keys");
    endtask

    task automatic test_async_reset();
        entry_ready = 1'b0;
        press(4'd1);
        press(4'd2);
        n_checks++;
        if (live_len !== 3'd2) $display("FAIL arst_pre: got len=%0d, want 2", live_len);
        else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({entry_valid, live_bcd, live_len, busy, err, timeout} !== '0)
            $display("FAIL arst_clear: got live=%h/%0d busy=%b, want 0", live_bcd, live_len, busy);
        else n_pass++;
        #1 rst = 1'b0;
        press(4'd5);
        n_checks++;
        if ({busy, live_bcd, live_len} !== {1'b1, 16'h0005, 3'd1})
            $display("FAIL arst_after: got busy=%b %h/%0d, want 1 0005/1", busy, live_bcd, live_len);
        else n_pass++;
        entry_ready = 1'b1;
        sb.push_back('{bcd: 16'h0005, len: 3'd1, term: TERM_HASH});
        press(KEY_HASH);
        drain("arst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_overflow();
        test_timeout();
        test_idle_keys();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
